// File: rtl/tap_regs.sv
// JTAG instruction and data registers driven by an external TAP controller's state code.
// Supports IDCODE (32-bit), USER (8-bit, writable), and BYPASS for all other instructions.
module tap_regs #(
  parameter logic [31:0] IDCODE   = 32'h1000_0001,
  parameter logic [7:0]  USER_RST = 8'h00
) (
  input  logic       GCLK_Pad,
  input  logic       TRST_Pad,
  input  logic [3:0] state_obs,
  input  logic       TDI_Pad,
  output logic       TDO_Pad,
  output logic [3:0] ir_out,
  output logic [7:0] user_data,
  output logic       update_strobe
);

  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {DR_BYP, DR_ID, DR_USR} dr_sel_e;

  typedef struct packed {
    logic [31:0] id;
    logic [7:0]  usr;
    logic        byp;
  } dr_t;

  localparam logic [3:0] INS_IDCODE = 4'b0001;
  localparam logic [3:0] INS_USER   = 4'b0010;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  tap_state_e st;
  dr_sel_e    sel;
  logic [3:0] ir_sh;
  dr_t        dr;

  assign st = tap_state_e'(state_obs);

  // DR selection follows only the committed instruction, never the IR shift stage.
  always_comb begin
    sel = DR_BYP;
    if (ir_out == INS_IDCODE)    sel = DR_ID;
    else if (ir_out == INS_USER) sel = DR_USR;
  end

  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      ir_out        <= INS_IDCODE;
      ir_sh         <= IR_CAPTURE;
      dr            <= '0;
      user_data     <= USER_RST;
      update_strobe <= 1'b0;
    end else begin
      update_strobe <= 1'b0;
      case (st)
        TLR:    ir_out <= INS_IDCODE;
        CAP_IR: ir_sh  <= IR_CAPTURE;
        SH_IR:  ir_sh  <= {TDI_Pad, ir_sh[3:1]};
        UPD_IR: ir_out <= ir_sh;
        CAP_DR: begin
          case (sel)
            DR_ID:   dr.id  <= IDCODE;
            DR_USR:  dr.usr <= user_data;
            default: dr.byp <= 1'b0;
          endcase
        end
        SH_DR: begin
          case (sel)
            DR_ID:   dr.id  <= {TDI_Pad, dr.id[31:1]};
            DR_USR:  dr.usr <= {TDI_Pad, dr.usr[7:1]};
            default: dr.byp <= TDI_Pad;
          endcase
        end
        UPD_DR: begin
          if (sel == DR_USR) begin
            user_data     <= dr.usr;
            update_strobe <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    TDO_Pad = 1'b0;
    if (st == SH_IR) begin
      TDO_Pad = ir_sh[0];
    end else if (st == SH_DR) begin
      case (sel)
        DR_ID:   TDO_Pad = dr.id[0];
        DR_USR:  TDO_Pad = dr.usr[0];
        default: TDO_Pad = dr.byp;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_regs.sv
// Bench for tap_regs: fixed vector table, hand-written scan sequences, and randomized
// state/TDI traffic checked against a queue-based register model.
module tb_tap_regs;

  localparam logic [31:0] IDV = 32'h1000_0001;
  localparam logic [7:0]  URST = 8'h00;

  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
                         SHDR = 4'h2, EX1DR = 4'h1, PAUDR = 4'h3, EX2DR = 4'h0,
                         UPDDR = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR = 4'hA,
                         EX1IR = 4'h9, PAUIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD;

  logic       GCLK_Pad, TRST_Pad, TDI_Pad, TDO_Pad, update_strobe;
  logic [3:0] state_obs, ir_out;
  logic [7:0] user_data;

  tap_regs #(.IDCODE(IDV), .USER_RST(URST)) dut (
    .GCLK_Pad(GCLK_Pad), .TRST_Pad(TRST_Pad), .state_obs(state_obs),
    .TDI_Pad(TDI_Pad), .TDO_Pad(TDO_Pad), .ir_out(ir_out),
    .user_data(user_data), .update_strobe(update_strobe)
  );

  initial GCLK_Pad = 1'b0;
  always #5 GCLK_Pad = ~GCLK_Pad;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: each register is a bit queue, LSB at the front (next bit out on TDO).
  typedef bit bq_t[$];
  bq_t q_ir, q_id, q_usr, q_byp;
  logic [3:0] m_ir;
  logic [7:0] m_user;
  logic       m_stb;

  function automatic bq_t to_q(input logic [31:0] v, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(v[i]);
    return q;
  endfunction

  function automatic logic [31:0] qval(input bq_t q);
    logic [31:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_ir = 4'h1; m_user = URST; m_stb = 1'b0;
    q_ir = to_q(32'h5, 4); q_id = to_q(32'h0, 32);
    q_usr = to_q(32'h0, 8); q_byp = to_q(32'h0, 1);
  endtask

  task automatic model_step(input logic [3:0] st, input logic tdi, output logic et);
    bit d;
    et = 1'b0;
    if (st == SHIR) et = q_ir[0];
    else if (st == SHDR) et = (m_ir == 4'h1) ? q_id[0] : (m_ir == 4'h2) ? q_usr[0] : q_byp[0];
    m_stb = 1'b0;
    case (st)
      TLR:   m_ir = 4'h1;
      CAPIR: q_ir = to_q(32'h5, 4);
      SHIR:  begin d = q_ir.pop_front(); q_ir.push_back(tdi); end
      UPDIR: m_ir = qval(q_ir)[3:0];
      CAPDR: begin
        if (m_ir == 4'h1)      q_id  = to_q(IDV, 32);
        else if (m_ir == 4'h2) q_usr = to_q({24'd0, m_user}, 8);
        else                   q_byp = to_q(32'h0, 1);
      end
      SHDR: begin
        if (m_ir == 4'h1)      begin d = q_id.pop_front();  q_id.push_back(tdi);  end
        else if (m_ir == 4'h2) begin d = q_usr.pop_front(); q_usr.push_back(tdi); end
        else                   begin d = q_byp.pop_front(); q_byp.push_back(tdi); end
      end
      UPDDR: if (m_ir == 4'h2) begin m_user = qval(q_usr)[7:0]; m_stb = 1'b1; end
      default: ;
    endcase
  endtask

  // One TAP cycle: called at posedge+1, returns at the following posedge+1.
  task automatic cyc(input logic [3:0] st, input logic tdi, output logic tdo);
    logic et;
    state_obs = st; TDI_Pad = tdi;
    #1 tdo = TDO_Pad;
    model_step(st, tdi, et);
    if (chk_model) chk("rnd_tdo", 32'(tdo), 32'(et));
    @(posedge GCLK_Pad); #1;
    if (chk_model) begin
      chk("rnd_ir", 32'(ir_out), 32'(m_ir));
      chk("rnd_user", 32'(user_data), 32'(m_user));
      chk("rnd_strobe", 32'(update_strobe), 32'(m_stb));
    end
  endtask

  task automatic ir_scan(input logic [3:0] v);
    logic t;
    cyc(CAPIR, 1'b0, t);
    for (int i = 0; i < 4; i++) cyc(SHIR, v[i], t);
    cyc(EX1IR, 1'b0, t);
    cyc(UPDIR, 1'b0, t);
  endtask

  // Reset asserted mid-period; outputs must settle before the next rising edge.
  task automatic reset_mid(input string tag);
    #2 TRST_Pad = 1'b0;
    model_reset();
    #1;
    chk({tag, "_ir"}, 32'(ir_out), 32'h1);
    chk({tag, "_user"}, 32'(user_data), 32'(URST));
    chk({tag, "_strobe"}, 32'(update_strobe), 32'h0);
    @(posedge GCLK_Pad);
    @(negedge GCLK_Pad) TRST_Pad = 1'b1;
    @(posedge GCLK_Pad); #1;
  endtask

  typedef struct {
    logic [3:0] st; logic tdi; logic tdo; logic [3:0] ir; logic [7:0] usr; logic stb;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] st, input logic tdi, input logic tdo,
                     input logic [3:0] ir, input logic [7:0] usr, input logic stb);
    vec_t v;
    v.st = st; v.tdi = tdi; v.tdo = tdo; v.ir = ir; v.usr = usr; v.stb = stb;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       t;
    logic [3:0] ti, to, r4;
    logic [7:0] a5, v8;
    logic [31:0] word;
    int r;

    // IR scan 0,1,0,0 -> TDO 1,0,1,0; USER write A5; read-back; TLR.
    ti = 4'b0010; to = 4'b0101; a5 = 8'hA5;
    add(RTI, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0);
    add(SELDR, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0);
    add(SELIR, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0);
    add(CAPIR, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) add(SHIR, ti[i], to[i], 4'h1, 8'h00, 1'b0);
    add(EX1IR, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0);
    add(UPDIR, 1'b0, 1'b0, 4'h2, 8'h00, 1'b0);
    add(SELDR, 1'b0, 1'b0, 4'h2, 8'h00, 1'b0);
    add(CAPDR, 1'b0, 1'b0, 4'h2, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) add(SHDR, a5[i], 1'b0, 4'h2, 8'h00, 1'b0);
    add(EX1DR, 1'b0, 1'b0, 4'h2, 8'h00, 1'b0);
    add(UPDDR, 1'b0, 1'b0, 4'h2, 8'hA5, 1'b1);
    add(RTI, 1'b0, 1'b0, 4'h2, 8'hA5, 1'b0);
    add(SELDR, 1'b0, 1'b0, 4'h2, 8'hA5, 1'b0);
    add(CAPDR, 1'b0, 1'b0, 4'h2, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) add(SHDR, a5[i], a5[i], 4'h2, 8'hA5, 1'b0);
    add(EX1DR, 1'b0, 1'b0, 4'h2, 8'hA5, 1'b0);
    add(UPDDR, 1'b0, 1'b0, 4'h2, 8'hA5, 1'b1);
    add(TLR, 1'b0, 1'b0, 4'h1, 8'hA5, 1'b0);

    TRST_Pad = 1'b1; state_obs = RTI; TDI_Pad = 1'b0;
    #2 TRST_Pad = 1'b0;
    model_reset();
    repeat (2) @(negedge GCLK_Pad);
    TRST_Pad = 1'b1;
    @(posedge GCLK_Pad); #1;
    chk("rst_ir", 32'(ir_out), 32'h1);
    chk("rst_user", 32'(user_data), 32'(URST));
    chk("rst_strobe", 32'(update_strobe), 32'h0);
    chk("rst_tdo", 32'(TDO_Pad), 32'h0);

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].tdi, t);
      chk($sformatf("tbl%0d_tdo", i), 32'(t), 32'(tbl[i].tdo));
      chk($sformatf("tbl%0d_ir", i), 32'(ir_out), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d_user", i), 32'(user_data), 32'(tbl[i].usr));
      chk($sformatf("tbl%0d_strobe", i), 32'(update_strobe), 32'(tbl[i].stb));
    end

    // Reset mid-period while user_data holds A5.
    reset_mid("rst_mid");

    // IDCODE read straight after reset.
    cyc(CAPDR, 1'b0, t);
    word = '0;
    for (int i = 0; i < 32; i++) begin cyc(SHDR, 1'b0, t); word[i] = t; end
    chk("idcode_read", word, IDV);

    // IR shifting must not change DR selection before UpdIR.
    ir_scan(4'h2);
    cyc(CAPIR, 1'b0, t);
    for (int i = 0; i < 4; i++) cyc(SHIR, 1'b1, t);
    chk("ir_hold_during_shift", 32'(ir_out), 32'h2);
    cyc(EX1IR, 1'b0, t);
    cyc(UPDIR, 1'b0, t);
    chk("ir_upd_bypass", 32'(ir_out), 32'hF);

    // USER shift broken by a pause loop; no bits may be lost.
    ir_scan(4'h2);
    v8 = 8'h3C;
    cyc(CAPDR, 1'b0, t);
    for (int i = 0; i < 4; i++) cyc(SHDR, v8[i], t);
    cyc(EX1DR, 1'b0, t);
    repeat (3) cyc(PAUDR, 1'b0, t);
    cyc(EX2DR, 1'b0, t);
    for (int i = 4; i < 8; i++) cyc(SHDR, v8[i], t);
    cyc(EX1DR, 1'b0, t);
    chk("pause_no_early_update", 32'(user_data), 32'h0);
    cyc(UPDDR, 1'b0, t);
    chk("pause_user", 32'(user_data), 32'h3C);
    chk("pause_strobe", 32'(update_strobe), 32'h1);
    cyc(TLR, 1'b0, t);
    chk("tlr_ir", 32'(ir_out), 32'h1);
    chk("tlr_user_kept", 32'(user_data), 32'h3C);
    chk("tlr_strobe", 32'(update_strobe), 32'h0);

    // Unknown instruction 0111 acts as a one-bit bypass.
    ir_scan(4'h7);
    chk("byp_ir", 32'(ir_out), 32'h7);
    cyc(CAPDR, 1'b0, t);
    ti = 4'b0101; to = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cyc(SHDR, ti[i], t);
      chk($sformatf("byp_tdo%0d", i), 32'(t), 32'(to[i]));
    end
    cyc(EX1DR, 1'b0, t);
    cyc(UPDDR, 1'b0, t);
    chk("byp_no_strobe", 32'(update_strobe), 32'h0);
    chk("byp_user_kept", 32'(user_data), 32'h3C);

    // Reset during a USER shift leaves no partial update behind.
    ir_scan(4'h2);
    cyc(CAPDR, 1'b0, t);
    repeat (3) cyc(SHDR, 1'b1, t);
    reset_mid("abort");
    cyc(UPDDR, 1'b0, t);
    chk("abort_no_user_sel", 32'(update_strobe), 32'h0);

    // Randomized traffic against the model.
    chk_model = 1'b1;
    for (int b = 0; b < 60; b++) begin
      r = $urandom_range(0, 3);
      r4 = 4'($urandom_range(0, 15));
      ir_scan(r == 0 ? 4'h1 : r == 1 ? 4'h2 : r == 2 ? 4'hF : r4);
      cyc(CAPDR, 1'($urandom_range(0, 1)), t);
      for (int c = 0; c < 24; c++) begin
        r = $urandom_range(0, 27);
        if (r < 16) r4 = 4'(r);
        else if (r < 22) r4 = SHDR;
        else if (r < 24) r4 = UPDDR;
        else if (r < 26) r4 = PAUDR;
        else r4 = SHIR;
        cyc(r4, 1'($urandom_range(0, 1)), t);
      end
    end
    chk_model = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tap_regs.md
TAP_REGS -- requirements
Module: tap_regs

Interface
REQ-001 SHALL provide parameter IDCODE, default 32'h1000_0001, the 32-bit identification value loaded in Capture-DR under IDCODE.
REQ-002 SHALL provide parameter USER_RST, default 8'h00, the reset value of user_data.
REQ-003 SHALL provide port GCLK_Pad  input  1  single clock; all state elements update on its rising edge.
REQ-004 SHALL provide port TRST_Pad  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port state_obs  input  4  current TAP controller state code, driven by the upstream TAP controller's state_obs3..0 (bit 3 = state_obs3).
REQ-006 SHALL provide port TDI_Pad  input  1  serial test data in.
REQ-007 SHALL provide port TDO_Pad  output  1  serial test data out.
REQ-008 SHALL provide port ir_out  output  4  active (updated) instruction.
REQ-009 SHALL provide port user_data  output  8  parallel USER data register.
REQ-010 SHALL provide port update_strobe  output  1  one-cycle pulse when user_data is written.

Function
REQ-011 SHALL decode state_obs as: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
REQ-012 SHALL treat state_obs as the state occupied during the current cycle; the action for a state takes effect at the rising edge that ends that cycle.
REQ-013 SHALL implement instructions: 4'b0001 IDCODE, 4'b0010 USER, 4'b1111 BYPASS; every other code behaves as BYPASS.
REQ-014 SHALL in CapIR load the 4-bit IR shift register with 4'b0101.
REQ-015 SHALL in ShIR shift the IR shift register right, TDI_Pad into bit 3.
REQ-016 SHALL in UpdIR copy the IR shift register into ir_out.
REQ-017 SHALL in TLR set ir_out to 4'b0001 synchronously, every TLR cycle.
REQ-018 SHALL in CapDR load the DR selected by ir_out: IDCODE 32-bit shift <= IDCODE; USER 8-bit shift <= user_data; BYPASS 1-bit <= 0.
REQ-019 SHALL in ShDR shift only the selected DR right, TDI_Pad into its MSB.
REQ-020 SHALL in UpdDR with ir_out=USER load user_data from the USER shift register and assert update_strobe for exactly the following cycle; with any other instruction, no update and no strobe.
REQ-021 SHALL hold all registers unchanged in SelDR, SelIR, Ex1/Ex2/Pause states and RTI.
REQ-022 SHALL drive TDO_Pad combinationally: in ShIR, bit 0 of the IR shift register; in ShDR, bit 0 of the selected DR; in all other states, 0.
REQ-023 SHALL select the DR from ir_out only; IR shifting in progress SHALL NOT change DR selection before UpdIR.
REQ-024 SHALL tolerate arbitrary Pause/Exit loops mid-shift with no loss of shifted bits.

Reset
REQ-025 SHALL on TRST_Pad low, immediately and regardless of GCLK_Pad: ir_out=4'b0001, IR shift=4'b0101, all DR shift registers=0, user_data=USER_RST, update_strobe=0.
REQ-026 SHALL with TRST_Pad low and a shift in progress abort that shift, leaving no partial updates to ir_out or user_data.
REQ-027 SHALL leave user_data unchanged by the synchronous TLR state (REQ-017 affects ir_out only).

Verification
REQ-028 Reset: drive TRST_Pad low mid-clock-period -> ir_out=0001, user_data=00 and update_strobe=0 before the next edge.
REQ-029 IDCODE read: after reset, sequence CapDR, 32x ShDR with TDI=0 -> TDO bits LSB-first equal 32'h1000_0001 (first bit 1, then 0s, bit 28 = 1).
REQ-030 IR scan: CapIR, 4x ShIR with TDI=0,1,0,0, UpdIR -> TDO shows 1,0,1,0; ir_out=0010 after UpdIR edge.
REQ-031 USER write: ir_out=0010, CapDR, 8x ShDR with TDI LSB-first for 8'hA5, UpdDR -> user_data=A5, update_strobe high exactly one cycle; next CapDR plus shift returns A5 on TDO.
REQ-032 BYPASS/unknown: ir_out=0111, CapDR, ShDR with TDI=1,0,1 -> TDO=0,1,0 (one-cycle delay); UpdDR -> no strobe, user_data unchanged.
REQ-033 Pause/TLR: USER shift of 4 bits, Ex1DR, 3x PauDR, Ex2DR, 4 more ShDR, UpdDR -> user_data equals all 8 bits; then one TLR cycle -> ir_out=0001, user_data retained.
